// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field positions,
// the state enumeration and the packed control-word layout.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        ALU_AND,
        ALU_OR,
        ALU_ADD,
        ALU_SUB
    } alu_sel_t;

    // Field order matches the concatenation that drives the top-level ports
    typedef struct packed {
        logic pc_out;
        logic zhigh_out;
        logic zlow_out;
        logic mdr_out;
        logic mar_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic inc_pc;
        logic read;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic alu_and;
        logic alu_or;
        logic alu_add;
        logic alu_sub;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: ALU / NOP / HALT / illegal plus the ALU strobe select.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output logic       is_alu,
    output logic       is_nop,
    output logic       is_halt,
    output logic       is_illegal,
    output alu_sel_t   alu_sel
);

    always_comb begin
        is_alu     = 1'b0;
        is_nop     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        alu_sel    = ALU_AND;
        case (opcode)
            OP_AND: begin
                is_alu  = 1'b1;
                alu_sel = ALU_AND;
            end
            OP_OR: begin
                is_alu  = 1'b1;
                alu_sel = ALU_OR;
            end
            OP_ADD: begin
                is_alu  = 1'b1;
                alu_sel = ALU_ADD;
            end
            OP_SUB: begin
                is_alu  = 1'b1;
                alu_sel = ALU_SUB;
            end
            OP_NOP:  is_nop     = 1'b1;
            OP_HALT: is_halt    = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control sequencer with registered Moore outputs.
// Optional macro CTRL_MEM_WAIT_EN makes T1 wait for Mem_ready.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Run,
    input  logic [31:0] IR,
    input  logic        Mem_ready,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        AND,
    output logic        OR,
    output logic        ADD,
    output logic        SUB,
    output logic        Busy,
    output logic        Halted,
    output logic        Fault,
    output logic [15:0] Instr_count
);

    state_t   state;
    state_t   next_state;
    ctrl_t    ctrl;
    logic     is_alu;
    logic     is_nop;
    logic     is_halt;
    logic     is_illegal;
    alu_sel_t alu_sel;
    logic     unused_bits;

`ifdef CTRL_MEM_WAIT_EN
    assign unused_bits = ^IR[RA_MSB:0];
`else
    assign unused_bits = ^{IR[RA_MSB:0], Mem_ready};
`endif

    ctrl_decode u_decode (
        .opcode     (IR[OP_MSB:OP_LSB]),
        .is_alu     (is_alu),
        .is_nop     (is_nop),
        .is_halt    (is_halt),
        .is_illegal (is_illegal),
        .alu_sel    (alu_sel)
    );

    // Control word for a state; registering it alongside the state keeps outputs aligned with it
    function automatic ctrl_t ctrl_for(input state_t s, input logic alu, input alu_sel_t sel);
        ctrl_t c;
        c = '0;
        case (s)
            S_T0: begin
                c.pc_out = 1'b1;
                c.mar_in = 1'b1;
                c.inc_pc = 1'b1;
                c.z_in   = 1'b1;
            end
            S_T1: begin
                c.zlow_out = 1'b1;
                c.pc_in    = 1'b1;
                c.read     = 1'b1;
                c.mdr_in   = 1'b1;
            end
            S_T2: begin
                c.mdr_out = 1'b1;
                c.ir_in   = 1'b1;
            end
            S_T3: begin
                c.grb   = alu;
                c.r_out = alu;
                c.y_in  = alu;
            end
            S_T4: begin
                c.grc   = 1'b1;
                c.r_out = 1'b1;
                c.z_in  = 1'b1;
                case (sel)
                    ALU_AND: c.alu_and = 1'b1;
                    ALU_OR:  c.alu_or  = 1'b1;
                    ALU_ADD: c.alu_add = 1'b1;
                    default: c.alu_sub = 1'b1;
                endcase
            end
            S_T5: begin
                c.zlow_out = 1'b1;
                c.gra      = 1'b1;
                c.r_in     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: next_state = Run ? S_T0 : S_IDLE;
            S_T0:   next_state = S_T1;
`ifdef CTRL_MEM_WAIT_EN
            S_T1:   next_state = Mem_ready ? S_T2 : S_T1;
`else
            S_T1:   next_state = S_T2;
`endif
            S_T2:   next_state = S_T3;
            S_T3: begin
                if (is_illegal)
                    next_state = S_ERR;
                else if (is_halt)
                    next_state = S_HALT;
                else if (is_nop)
                    next_state = S_T0;
                else
                    next_state = S_T4;
            end
            S_T4:   next_state = S_T5;
            S_T5:   next_state = S_T0;
            S_HALT: next_state = S_HALT;
            S_ERR:  next_state = S_ERR;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state       <= S_IDLE;
            ctrl        <= '0;
            Busy        <= 1'b0;
            Halted      <= 1'b0;
            Fault       <= 1'b0;
            Instr_count <= 16'd0;
        end else begin
            state  <= next_state;
            ctrl   <= ctrl_for(next_state, is_alu, alu_sel);
            Busy   <= (next_state != S_IDLE) && (next_state != S_HALT);
            Halted <= (next_state == S_HALT);
            Fault  <= (next_state == S_ERR);
            if ((state == S_T5) || ((state == S_T3) && is_nop))
                Instr_count <= Instr_count + 16'd1;
        end
    end

    assign {PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read,
            Gra, Grb, Grc, Rin, Rout, AND, OR, ADD, SUB} = ctrl;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: Clock  in  1  rising-edge clock; Clear  in  1  synchronous active-high reset.
REQ-002 SHALL have these inputs:
- Run  in  1  start fetching from Idle.
- IR  in  32  instruction register contents.
- Mem_ready  in  1  memory read data valid.
REQ-003 SHALL have these datapath control outputs, all 1 bit: PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read.
REQ-004 SHALL have these register-file select outputs:
- Gra, Grb, Grc  out  1  select IR field Ra/Rb/Rc.
- Rin, Rout  out  1  write/drive the selected register.
REQ-005 SHALL have these ALU operation strobes: AND, OR, ADD, SUB  out  1  each.
REQ-006 SHALL have these status outputs:
- Busy  out  1  state is neither Idle nor Halted.
- Halted  out  1  HALT executed.
- Fault  out  1  illegal opcode seen.
- Instr_count  out  16  instructions completed.

Function
REQ-007 SHALL decode opcode IR[31:27] as AND=00010, OR=00011, ADD=00100, SUB=00101, NOP=11010, HALT=11011; every other value is illegal.
REQ-008 SHALL have register fields Ra=IR[26:23], Rb=IR[22:19] and Rc=IR[18:15]; register numbers are driven by the datapath, and this block drives only Gra/Grb/Grc.
REQ-009 SHALL implement states Idle, T0, T1, T2, T3, T4, T5, Halt and Err.
REQ-010 SHALL register all control outputs as a Moore function of state; each output is valid for exactly the cycle(s) its state is held.
REQ-011 SHALL transition Idle->T0 on the edge where Run=1, and otherwise stay in Idle.
REQ-012 SHALL drive PCout, MARin, IncPC and Zin in T0, then go to T1.
REQ-013 SHALL drive Zlowout, PCin, Read and MDRin in T1, then go to T2.
REQ-014 SHALL drive MDRout and IRin in T2, then go to T3.
REQ-015 SHALL branch in T3 on the opcode of the IR loaded in T2:
- ALU ops: drive Grb, Rout and Yin, then go to T4.
- NOP: all outputs low, then go to T0.
- HALT: go to Halt.
- Illegal: go to Err.
REQ-016 SHALL drive Grc, Rout, Zin and exactly one ALU strobe matching the opcode in T4, then go to T5.
REQ-017 SHALL drive Zlowout, Gra and Rin in T5, then go to T0.
REQ-018 SHALL increment Instr_count by 1 on leaving T5 and on leaving T3 for NOP; the count wraps from 0xFFFF to 0x0000.
REQ-019 SHALL assert Halted in Halt and Fault in Err; both states hold all controls low and are left only by Clear.
REQ-020 SHALL never assert two bus drivers (PCout, Zhighout, Zlowout, MDRout, Rout) in the same cycle; Zhighout is reserved and always 0.
REQ-021 SHALL take 6 cycles per ALU instruction and 4 cycles per NOP when waits are compiled out.
REQ-022 SHALL ignore Run outside Idle.

Reset
REQ-023 SHALL, when Clear=1 at a rising edge, enter Idle, drive all control outputs to 0, set Busy=0, Halted=0, Fault=0 and Instr_count=0; this applies from any state, including mid-instruction.
REQ-024 SHALL give Clear priority over Run and Mem_ready in the same cycle.

Configuration
REQ-025 SHALL support the macro CTRL_MEM_WAIT_EN:
- Defined: T1 holds, with its controls asserted, until Mem_ready=1, then goes to T2.
- Undefined: Mem_ready is ignored and T1 lasts one cycle.

Structure
REQ-026 SHALL place the opcode constants, the state enumeration and the field-position constants in the shared package cpu_ctrl_pkg.
REQ-027 SHALL place opcode classification (alu/nop/halt/illegal plus ALU strobe select) in one combinational sub-module, ctrl_decode.

Verification
REQ-028 SHALL be covered by these directed scenarios:
- Clear, Run=1, IR=0x1A920000 (OR R5,R2,R4) -> T3: Grb+Rout+Yin; T4: Grc+Rout+OR+Zin; T5: Zlowout+Gra+Rin; Instr_count=1 after 6 cycles.
- IR opcode ADD, AND, SUB in sequence -> only the matching strobe in each T4; Instr_count=3 after 18 cycles.
- IR=0xD0000000 (NOP) then 0xD8000000 (HALT) -> NOP costs 4 cycles and counts 1; then Halted=1 and Busy=0, with state held for 10 cycles.
- IR opcode 11111 -> Fault=1 in the cycle after T3; Clear -> Fault=0 and Idle.
- Clear asserted during T4 -> the next cycle has all controls 0 and Instr_count unchanged at 0.
- CTRL_MEM_WAIT_EN defined, Mem_ready low 3 cycles -> T1 controls held 4 cycles; the instruction completes in 9 cycles.
